// File: rtl/tx_ram_pkt_ctrl.sv
// Store-and-forward packet FIFO controller for the TX SDP RAM.
// Optional statistics counters: `define TX_RAM_CTRL_STAT_EN.
module tx_ram_pkt_ctrl #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 64,
  parameter int RAM_OUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,

  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,

  output logic [DATA_WIDTH:0]   ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH:0]   ram_rd_data,
  output logic                  ram_rst,

  output logic [ADDR_WIDTH:0]   level,
  output logic                  ovf_drop,
  output logic [31:0]           frame_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam bit OREG = (RAM_OUT_REG != 0);

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_FRAME,
    WR_DISCARD
  } wr_st_t;

  wr_st_t      wr_st;
  logic [AW:0] wr_ptr;
  logic [AW:0] cmt_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] lvl;
  logic        full;
  logic        run;
  logic        acc;
  logic        ovf_hit;
  logic        ovf_q;

  logic [1:0]  ob_cnt;
  logic [DW:0] ob0;
  logic [DW:0] ob1;
  logic        infl_q;
  logic        push;
  logic        pop;
  logic [1:0]  occ_n;
  logic        rd_issue;

  assign ram_rst = ~rst_n;

  assign lvl   = wr_ptr - rd_ptr;
  assign full  = (lvl == DEPTH);
  assign level = lvl;

  assign s_ready = run &
    ((wr_st == WR_DISCARD) | ~full);

  assign acc = s_valid & s_ready;

  // A frame that alone fills the RAM can never commit.
  assign ovf_hit = (wr_st == WR_FRAME) &
    full & (cmt_ptr == rd_ptr);

  assign ram_wr_en   = acc & (wr_st != WR_DISCARD);
  assign ram_wr_addr = wr_ptr[AW-1:0];
  assign ram_wr_data = {s_last, s_data};
  assign ovf_drop    = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_st   <= WR_IDLE;
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      ovf_q   <= 1'b0;
      run     <= 1'b0;
    end else begin
      run   <= 1'b1;
      ovf_q <= 1'b0;
      unique case (wr_st)
        WR_IDLE, WR_FRAME: begin
          if (ovf_hit) begin
            wr_ptr <= cmt_ptr;
            ovf_q  <= 1'b1;
            wr_st  <= WR_DISCARD;
          end else if (acc) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (s_last) begin
              cmt_ptr <= wr_ptr + 1'b1;
              wr_st   <= WR_IDLE;
            end else begin
              wr_st <= WR_FRAME;
            end
          end
        end
        WR_DISCARD: begin
          if (acc && s_last)
            wr_st <= WR_IDLE;
        end
        default: wr_st <= WR_IDLE;
      endcase
    end
  end

  assign m_valid = (ob_cnt != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = ob0[DW-1:0];
  assign m_last  = ob0[DW];

  // Slot freed by this cycle's pop is credited so
  // a registered RAM output still streams 1 beat/clk.
  assign occ_n = ob_cnt + {1'b0, infl_q}
    - {1'b0, pop};

  assign rd_issue = (rd_ptr != cmt_ptr) &&
    (occ_n < 2'd2);

  assign push = OREG ? infl_q : rd_issue;

  assign ram_rd_addr = rd_ptr[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      infl_q <= 1'b0;
    end else begin
      infl_q <= OREG & rd_issue;
      if (rd_issue)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_cnt <= 2'd0;
      ob0    <= '0;
      ob1    <= '0;
    end else begin
      unique case (1'b1)
        push && !pop: begin
          if (ob_cnt == 2'd0)
            ob0 <= ram_rd_data;
          else
            ob1 <= ram_rd_data;
          ob_cnt <= ob_cnt + 2'd1;
        end
        !push && pop: begin
          ob0    <= ob1;
          ob_cnt <= ob_cnt - 2'd1;
        end
        push && pop: begin
          if (ob_cnt == 2'd1) begin
            ob0 <= ram_rd_data;
          end else begin
            ob0 <= ob1;
            ob1 <= ram_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TX_RAM_CTRL_STAT_EN
  logic [31:0] frm_q;
  logic [15:0] drp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_q <= '0;
      drp_q <= '0;
    end else begin
      if (pop && m_last)
        frm_q <= frm_q + 32'd1;
      if (ovf_q && (drp_q != 16'hFFFF))
        drp_q <= drp_q + 16'd1;
    end
  end

  assign frame_cnt = frm_q;
  assign drop_cnt  = drp_q;
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_tx_ram_pkt_ctrl.sv
// Scoreboard bench for tx_ram_pkt_ctrl with a behavioural SDP RAM.
// Honours `define TX_RAM_CTRL_STAT_EN for the counter checks.
module tb_tx_ram_pkt_ctrl;

  localparam int AW   = 4;
  localparam int DW   = 64;
  localparam int OREG = 0;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW:0]   ram_wr_data;
  logic [AW-1:0] ram_wr_addr;
  logic          ram_wr_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW:0]   ram_rd_data;
  logic          ram_rst;
  logic [AW:0]   level;
  logic          ovf_drop;
  logic [31:0]   frame_cnt;
  logic [15:0]   drop_cnt;

  int n_chk = 0;
  int n_err = 0;
  int n_ovf = 0;

  logic [DW:0] sbq[$];

  tx_ram_pkt_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RAM_OUT_REG(OREG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .ram_wr_data(ram_wr_data),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_en  (ram_wr_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .ram_rst    (ram_rst),
    .level      (level),
    .ovf_drop   (ovf_drop),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt)
  );

  logic [DW:0] mem [2**AW];
  logic [DW:0] rd_q;

  always @(posedge clk)
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;

  always @(posedge clk or posedge ram_rst)
    if (ram_rst) rd_q <= '0;
    else         rd_q <= mem[ram_rd_addr];

  assign ram_rd_data = (OREG != 0) ? rd_q
                                   : mem[ram_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [DW:0] obs,
                     input logic [DW:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               tag, obs, want);
    end
  endtask

  logic        hold_q;
  logic [DW:0] hold_b;
  logic [DW:0] exp_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
    end else begin
      if (hold_q) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", {m_last, m_data}, hold_b);
      end
      if (m_valid && m_ready) begin
        if (sbq.size() > 0) begin
          exp_b = sbq.pop_front();
          chk("beat", {m_last, m_data}, exp_b);
        end else begin
          chk("spurious_valid", m_valid, 0);
        end
      end
      if (ovf_drop) n_ovf++;
      hold_q <= m_valid & ~m_ready;
      hold_b <= {m_last, m_data};
    end
  end

  task automatic send_beat(input logic [DW-1:0] d,
                           input bit last,
                           input int vp);
    int  t;
    bit  acc;
    t      = 0;
    acc    = 1'b0;
    s_data = d;
    s_last = last;
    while (!acc) begin
      s_valid = ($urandom_range(99) < vp);
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      t++;
      if (!acc && t > 3000) begin
        chk("accept_timeout", acc, 1);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int len,
                            input int vp,
                            input bit keep);
    logic [DW-1:0] d;
    bit lst;
    for (int i = 0; i < len; i++) begin
      d   = {$urandom, $urandom};
      lst = (i == len - 1);
      if (keep) sbq.push_back({lst, d});
      send_beat(d, lst, vp);
    end
  endtask

  task automatic drain();
    int t;
    t       = 0;
    m_ready = 1'b1;
    while ((sbq.size() != 0 || m_valid) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain_queue", sbq.size(), 0);
    chk("drain_level", level, 0);
    chk("drain_valid", m_valid, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  bit done;
  int cyc;
  int ovf0;

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf_drop, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", s_ready, 1);

    // 3-beat frame and first-beat latency
    m_ready = 1'b1;
    sbq.push_back({1'b0, 64'h11});
    sbq.push_back({1'b0, 64'h22});
    sbq.push_back({1'b1, 64'h33});
    send_beat(64'h11, 1'b0, 100);
    send_beat(64'h22, 1'b0, 100);
    send_beat(64'h33, 1'b1, 100);
    cyc = 0;
    while (!m_valid && cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", cyc, OREG + 1);
    drain();

    // fill under backpressure; 2 beats sit in the output buffer
    m_ready = 1'b0;
    send_frame(8, 100, 1'b1);
    send_frame(8, 100, 1'b1);
    chk("lvl_16_sent", level, 2**AW - 2);
    chk("rdy_16_sent", s_ready, 1);
    send_frame(2, 100, 1'b1);
    chk("lvl_full", level, 2**AW);
    chk("rdy_full", s_ready, 0);
    chk("valid_full", m_valid, 1);
    drain();

    // oversize frame dropped, next frame intact
    m_ready = 1'b1;
    ovf0    = n_ovf;
    send_frame(20, 100, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_pulses", n_ovf - ovf0, 1);
    chk("ovf_level", level, 0);
    chk("ovf_valid", m_valid, 0);
    send_frame(2, 100, 1'b1);
    drain();

    // random traffic with wrap and backpressure
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 40; f++)
          send_frame($urandom_range(16, 1), 50, 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_ready = 1'($urandom_range(1));
        end
      end
    join
    drain();

    // reset with a committed frame and a partial frame held
    m_ready = 1'b0;
    send_frame(3, 100, 1'b1);
    send_beat(64'hAA, 1'b0, 100);
    send_beat(64'hBB, 1'b0, 100);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", m_valid, 0);
    chk("midrst_level", level, 0);
    chk("midrst_ready", s_ready, 0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    send_frame(2, 100, 1'b1);
    drain();

    // statistics: 5 good frames, 2 oversize
    do_reset();
    m_ready = 1'b1;
    ovf0    = n_ovf;
    send_frame(3, 100, 1'b1);
    send_frame(18, 100, 1'b0);
    send_frame(5, 100, 1'b1);
    send_frame(1, 100, 1'b1);
    send_frame(17, 100, 1'b0);
    send_frame(8, 100, 1'b1);
    send_frame(2, 100, 1'b1);
    drain();
    chk("stat_ovf_pulses", n_ovf - ovf0, 2);
`ifdef TX_RAM_CTRL_STAT_EN
    chk("frame_cnt", frame_cnt, 5);
    chk("drop_cnt", drop_cnt, 2);
`else
    chk("frame_cnt", frame_cnt, 0);
    chk("drop_cnt", drop_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
